mem_req_ctrl: RTL

Memory request controller for the multi-cycle TOY core. It sits directly upstream of the 4096×16 unified memory. It accepts instruction-fetch requests from the fetch/IR stage and load/store requests from the datapath, and arbitrates between them. It sequences the memory's `rd`/`wr`/address/write-data pins and returns registered read data with a one-cycle acknowledge.

---
 rtl/mem_req_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: arbitrates TOY-core fetch and load/store requests onto the unified memory.
// Define MEM_REQ_FAIR_ARB_EN for round-robin arbitration instead of data-over-fetch priority.
module mem_req_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              grant;
    logic              grant_data;
    logic              owner_data;
    logic              we_lat;
    logic [ADDR_W-1:0] addr_lat;
    logic [DATA_W-1:0] wdata_lat;
    logic              is_store;

    assign grant    = if_req | d_req;
    assign is_store = owner_data & we_lat;

`ifdef MEM_REQ_FAIR_ARB_EN
    // last_grant = 1 means data won most recently; a tie goes to the other port
    logic last_grant;

    always_comb begin
        grant_data = d_req & ~(if_req & last_grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b0;
        end else if (state == IDLE && grant) begin
            last_grant <= grant_data;
        end
    end
`else
    always_comb begin
        grant_data = d_req;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        if_ack     = 1'b0;
        d_ack      = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_rd     = ~is_store;
                mem_wr     = is_store;
                state_next = RESP;
            end
            RESP: begin
                if_ack     = ~owner_data;
                d_ack      = owner_data;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request fields are frozen at the grant so later requester changes cannot disturb the access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_data <= 1'b0;
            we_lat     <= 1'b0;
            addr_lat   <= '0;
            wdata_lat  <= '0;
        end else if (state == IDLE && grant) begin
            owner_data <= grant_data;
            we_lat     <= grant_data & d_we;
            addr_lat   <= grant_data ? d_addr : if_addr;
            wdata_lat  <= d_wdata;
        end
    end

    assign mem_addr = addr_lat;
    assign mem_wd   = wdata_lat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_data <= '0;
            d_rdata <= '0;
        end else if (state == ACCESS && !is_store) begin
            if (owner_data) begin
                d_rdata <= mem_rdata;
            end else begin
                if_data <= mem_rdata;
            end
        end
    end

endmodule
